// File: rtl/train_pkg.sv
// Shared train definitions: event codes and the fault classifier used by the event log.
package train_pkg;

    localparam logic [3:0] EV_GOTOWORK    = 4'b0000;
    localparam logic [3:0] EV_STOPWORK    = 4'b0001;
    localparam logic [3:0] EV_GOTOST      = 4'b0010;
    localparam logic [3:0] EV_WAIT        = 4'b0011;
    localparam logic [3:0] EV_DRSOPEN     = 4'b0100;
    localparam logic [3:0] EV_DRSCNTOPEN  = 4'b0101;
    localparam logic [3:0] EV_DRSCLOSE    = 4'b0110;
    localparam logic [3:0] EV_DRSCNTCLOSE = 4'b0111;
    localparam logic [3:0] EV_SMTHWRONG   = 4'b1000;

    // A code is a fault when the controller reports it could not complete a door
    // operation or flags a generic malfunction.
    function automatic logic is_fault(input logic [3:0] code);
        logic result;
        case (code)
            EV_SMTHWRONG,
            EV_DRSCNTOPEN,
            EV_DRSCNTCLOSE: result = 1'b1;
            default:        result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/evlog_fifo.sv
// Show-ahead FIFO for the event log. Pointers carry one extra wrap bit so
// full and empty can be told apart without a separate counter.
module evlog_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic              wr_en_s;
    logic              rd_en_s;

    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level   = wr_ptr_r - rd_ptr_r;
    assign rd_en_s = pop & ~empty;
    // A simultaneous pop frees the slot, so a full FIFO may still accept the push.
    assign wr_en_s = push & (~full | rd_en_s);
    // Head entry is presented combinationally; zero when nothing is stored.
    assign rdata   = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

    // Pointer registers: advance on accepted push/pop, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array: written only on an accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/train_event_log.sv
// Event logger for the train controller: logs every change of evnt_in into a
// show-ahead FIFO and raises alarm after FAULT_LIMIT consecutive fault codes.
// Optional macro TRAIN_EVLOG_TS_EN adds a free-running timestamp to each entry;
// without it out_ts is tied to 0.
module train_event_log
    import train_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TS_W        = 16,
    parameter int FAULT_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              evnt_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_code,
    output logic [TS_W-1:0]         out_ts,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    alarm
);

`ifdef TRAIN_EVLOG_TS_EN
    localparam int EW = 4 + TS_W;
`else
    localparam int EW = 4;
`endif
    localparam logic [3:0] LIMIT = 4'(FAULT_LIMIT);

    logic [3:0]     prev_r;
    logic [3:0]     fault_cnt_r;
    logic [3:0]     fault_nxt_s;
    logic           overflow_r;
    logic           alarm_r;
    logic           push_s;
    logic           pop_s;
    logic           full_s;
    logic           empty_s;
    logic [EW-1:0]  wdata_s;
    logic [EW-1:0]  rdata_s;

    assign push_s    = (evnt_in != prev_r);
    assign out_valid = ~empty_s;
    assign pop_s     = out_valid & out_ready;
    assign overflow  = overflow_r;
    assign alarm     = alarm_r;

`ifdef TRAIN_EVLOG_TS_EN
    localparam logic [TS_W-1:0] TS_ONE = {{(TS_W-1){1'b0}}, 1'b1};
    logic [TS_W-1:0] ts_r;

    // Free-running timestamp; wraps silently. Entries capture the pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_ONE;
        end
    end

    assign wdata_s  = {evnt_in, ts_r};
    assign out_code = rdata_s[EW-1 -: 4];
    assign out_ts   = rdata_s[TS_W-1:0];
`else
    assign wdata_s  = evnt_in;
    assign out_code = rdata_s;
    assign out_ts   = {TS_W{1'b0}};
`endif

    evlog_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    // Next consecutive-fault count: saturating increment on a pushed fault, clear on any other pushed code.
    always_comb begin
        fault_nxt_s = fault_cnt_r;
        if (push_s) begin
            if (is_fault(evnt_in)) begin
                if (fault_cnt_r < LIMIT) begin
                    fault_nxt_s = fault_cnt_r + 4'd1;
                end else begin
                    fault_nxt_s = fault_cnt_r;
                end
            end else begin
                fault_nxt_s = 4'd0;
            end
        end else begin
            fault_nxt_s = fault_cnt_r;
        end
    end

    // Change-detect history, fault count, sticky overflow and alarm state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_r      <= 4'b1111;
            fault_cnt_r <= 4'd0;
            overflow_r  <= 1'b0;
            alarm_r     <= 1'b0;
        end else begin
            prev_r      <= evnt_in;
            fault_cnt_r <= fault_nxt_s;
            if (push_s && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
            if (push_s && (evnt_in == EV_GOTOWORK)) begin
                alarm_r <= 1'b0;
            end else if (push_s && (fault_nxt_s == LIMIT)) begin
                alarm_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_train_event_log.sv
// Self-checking bench for train_event_log: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_train_event_log;

    localparam int DEPTH = 8;
    localparam int TS_W  = 4;
    localparam int LIM   = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      evnt_in;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_code;
    logic [TS_W-1:0] out_ts;
    logic [3:0]      level;
    logic            overflow;
    logic            alarm;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [3:0]      m_prev;
    logic [TS_W-1:0] m_ts;
    logic [3:0]      q_code[$];
    logic [TS_W-1:0] q_ts[$];
    bit              m_ovf;
    bit              m_alarm;
    int              m_cnt;

    always #5 clk = ~clk;

    train_event_log #(.DEPTH(DEPTH), .TS_W(TS_W), .FAULT_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset), .evnt_in(evnt_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_code(out_code), .out_ts(out_ts),
        .level(level), .overflow(overflow), .alarm(alarm)
    );

    function automatic bit fault_code(input logic [3:0] c);
        return (c == 4'd8) || (c == 4'd5) || (c == 4'd7);
    endfunction

    function automatic logic [TS_W-1:0] ts_expect(input logic [TS_W-1:0] t);
`ifdef TRAIN_EVLOG_TS_EN
        return t;
`else
        return {TS_W{1'b0}};
`endif
    endfunction

    task automatic model_reset();
        m_prev = 4'hF; m_ts = '0; m_ovf = 0; m_alarm = 0; m_cnt = 0;
        q_code.delete(); q_ts.delete();
    endtask

    // Drive one cycle of stimulus, advance the model, and land at posedge+1.
    task automatic step(input logic [3:0] code, input logic rdy);
        bit push, pop, was_full;
        evnt_in = code; out_ready = rdy;
        push = (code != m_prev);
        pop = (q_code.size() > 0) && rdy;
        was_full = (q_code.size() == DEPTH);
        if (pop) begin
            void'(q_code.pop_front()); void'(q_ts.pop_front());
        end
        if (push) begin
            if (!was_full || pop) begin
                q_code.push_back(code); q_ts.push_back(ts_expect(m_ts));
            end else begin
                m_ovf = 1;
            end
            if (fault_code(code)) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
            else m_cnt = 0;
            if (code == 4'd0) m_alarm = 0;
            else if (m_cnt == LIM) m_alarm = 1;
        end
        m_prev = code;
        m_ts = m_ts + 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q_code.size() > 0 && n < 2*DEPTH + 2) begin
            step(m_prev, 1'b1); n++;
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_timeout: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({out_valid, out_code, out_ts, level, overflow, alarm} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%0b code=%0h ts=%0h level=%0d ovf=%0b alarm=%0b required all 0",
                     out_valid, out_code, out_ts, level, overflow, alarm);
        end
    endtask

    task automatic test_first_entry();
        step(4'd1, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_code !== 4'd1 || out_ts !== ts_expect(4'd0) || level !== 4'd1) begin
            tests_failed++;
            $display("FAIL first_entry: valid=%0b code=%0h ts=%0h level=%0d required 1/1/%0h/1",
                     out_valid, out_code, out_ts, level, ts_expect(4'd0));
        end
        repeat (3) step(4'd1, 1'b0);
        tests_run++;
        if (level !== 4'd1) begin
            tests_failed++;
            $display("FAIL hold_no_push: level=%0d required 1", level);
        end
    endtask

    task automatic test_sequence();
        logic [3:0]      codes [5];
        logic [TS_W-1:0] tss   [5];
        codes = '{4'd1, 4'd0, 4'd2, 4'd3, 4'd4};
        tss   = '{4'd0, 4'd4, 4'd5, 4'd6, 4'd7};
        step(4'd0, 1'b0); step(4'd2, 1'b0); step(4'd3, 1'b0); step(4'd4, 1'b0);
        tests_run++;
        if (level !== 4'd5) begin
            tests_failed++;
            $display("FAIL seq_level: level=%0d required 5", level);
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_code !== codes[i] || out_ts !== ts_expect(tss[i])) begin
                tests_failed++;
                $display("FAIL seq_drain[%0d]: valid=%0b code=%0h ts=%0h required 1/%0h/%0h",
                         i, out_valid, out_code, out_ts, codes[i], ts_expect(tss[i]));
            end
            step(4'd4, 1'b1);
        end
        tests_run++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            tests_failed++;
            $display("FAIL seq_empty: valid=%0b level=%0d required 0/0", out_valid, level);
        end
    endtask

    task automatic test_alarm();
        logic [3:0] seq [9];
        logic       exp [9];
        seq = '{4'd8, 4'd5, 4'd7, 4'd4, 4'd0, 4'd8, 4'd5, 4'd7, 4'd0};
        exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            step(seq[i], 1'b1);
            tests_run++;
            if (alarm !== exp[i]) begin
                tests_failed++;
                $display("FAIL alarm[%0d] code=%0h: alarm=%0b required %0b", i, seq[i], alarm, exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        drain();
        while (m_ts != 4'd15 && n < 20) begin step(m_prev, 1'b1); n++; end
        step(4'd3, 1'b0);
        step(4'd6, 1'b0);
        tests_run++;
        if (out_code !== 4'd3 || out_ts !== ts_expect(4'd15)) begin
            tests_failed++;
            $display("FAIL wrap_ts15: code=%0h ts=%0h required 3/%0h", out_code, out_ts, ts_expect(4'd15));
        end
        step(4'd6, 1'b1);
        tests_run++;
        if (out_code !== 4'd6 || out_ts !== ts_expect(4'd0)) begin
            tests_failed++;
            $display("FAIL wrap_ts0: code=%0h ts=%0h required 6/%0h", out_code, out_ts, ts_expect(4'd0));
        end
        drain();
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic       r;
        logic [14:0] got, exp;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) c = m_prev;
            else c = 4'($urandom_range(0, 8));
            r = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(c, r);
            exp = {q_code.size() > 0,
                   (q_code.size() > 0) ? q_code[0] : 4'd0,
                   (q_ts.size() > 0) ? q_ts[0] : 4'd0,
                   4'(q_code.size()), m_ovf, m_alarm};
            got = {out_valid, out_code, out_ts, level, overflow, alarm};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL random[%0d]: got {v,code,ts,lvl,ovf,alm}=%h required %h", i, got, exp);
            end
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [3:0] pushed [11];
        for (int i = 0; i < 10; i++) begin
            pushed[i] = m_prev + 4'd1;
            step(pushed[i], 1'b0);
        end
        tests_run++;
        if (level !== 4'd8 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_full: level=%0d ovf=%0b required 8/1", level, overflow);
        end
        tests_run++;
        if (out_code !== pushed[0]) begin
            tests_failed++;
            $display("FAIL overflow_head: code=%0h required %0h", out_code, pushed[0]);
        end
        pushed[10] = m_prev + 4'd1;
        step(pushed[10], 1'b1);
        tests_run++;
        if (level !== 4'd8 || out_code !== pushed[1]) begin
            tests_failed++;
            $display("FAIL full_push_pop: level=%0d code=%0h required 8/%0h", level, out_code, pushed[1]);
        end
        for (int i = 0; i < 8; i++) begin
            logic [3:0] e;
            e = (i < 7) ? pushed[i+1] : pushed[10];
            tests_run++;
            if (out_code !== e) begin
                tests_failed++;
                $display("FAIL overflow_drain[%0d]: code=%0h required %0h", i, out_code, e);
            end
            step(m_prev, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        drain();
        for (int i = 0; i < 5; i++) step(m_prev + 4'd1, 1'b0);
        tests_run++;
        if (level !== 4'd5) begin
            tests_failed++;
            $display("FAIL mid_level: level=%0d required 5", level);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || alarm !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: valid=%0b level=%0d ovf=%0b alarm=%0b required 0/0/0/0",
                     out_valid, level, overflow, alarm);
        end
        #1;
        reset = 1'b1;
        model_reset();
        step(m_prev == 4'd3 ? 4'd2 : 4'd3, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_code !== 4'd3 || out_ts !== ts_expect(4'd0) || level !== 4'd1) begin
            tests_failed++;
            $display("FAIL post_reset_log: valid=%0b code=%0h ts=%0h level=%0d required 1/3/%0h/1",
                     out_valid, out_code, out_ts, level, ts_expect(4'd0));
        end
    endtask

    initial begin
        reset = 1'b0; evnt_in = 4'd0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        model_reset();
        test_first_entry();
        test_sequence();
        test_alarm();
        test_wrap();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/train_event_log.md
# train_event_log

Downstream consumer of the train controller's 4-bit `evnt` code. It samples `evnt` every cycle and detects code changes. Each new code is logged with a free-running timestamp into a small FIFO, drained over a valid/ready interface by the supervisor/display stage. It also tracks consecutive fault codes and raises a registered `alarm`.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `TS_W`, 16, timestamp width in bits
- `FAULT_LIMIT`, 3, consecutive logged faults that raise `alarm`; 1..15

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `evnt_in`  in  4  event code from the train controller; sampled on `clk` rising edge
- `out_valid`  out  1  FIFO head holds an entry
- `out_ready`  in  1  consumer accepts the head entry this cycle
- `out_code`  out  4  head entry code; 0 when empty
- `out_ts`  out  TS_W  head entry timestamp; 0 when empty
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `overflow`  out  1  sticky; an entry was dropped because the FIFO was full
- `alarm`  out  1  consecutive fault count has reached `FAULT_LIMIT`

## Operation
- Reset clears all state: `ts`=0, `prev`=4'b1111 (unused code), FIFO empty, `level`=0, `fault_cnt`=0.
  - `out_valid`, `overflow` and `alarm` are 0 at reset.
- `ts` increments every cycle and wraps from 2^TS_W−1 to 0. There is no flag on wrap.
- Change detect: `push` = (`evnt_in` != `prev`). `prev` <= `evnt_in` on every edge.
  - Because `prev` resets to 4'b1111, the first code after reset is always logged.
- On push, the entry {`evnt_in`, `ts`} is written at `wr_ptr`. The timestamp is the value of `ts` before the capture edge increments it.
- `pop` = `out_valid` & `out_ready`. It advances `rd_ptr` on the edge.
- The FIFO is show-ahead: `out_code`/`out_ts` reflect `mem[rd_ptr]` combinationally from registered pointers.
- Full with push and no pop: the entry is dropped, `overflow` is set (cleared only by reset), and `level` is unchanged.
- Full with push and pop in the same cycle: both happen and `level` stays at DEPTH. No overflow.
- Empty with push and no pop: the entry is written, `level`=1 and `out_valid`=1 next cycle.
- Pointers are log2(DEPTH)+1 bits. Full/empty are derived from the MSB plus pointer equality.
- Fault codes are 4'b1000 (SmthWrong), 4'b0101 (DrsCntOpen) and 4'b0111 (DrsCntClose).
- Fault tracking acts only on pushed codes, including ones dropped on overflow:
  - A fault code increments `fault_cnt`, saturating at `FAULT_LIMIT`.
  - Any other code clears `fault_cnt` to 0.
- `alarm` <= 1 when `fault_cnt` reaches `FAULT_LIMIT`. It clears only when code 4'b0000 (GoToWork) is pushed.

## Timing
- Change-to-visible latency is 1 cycle: `evnt_in` changes before edge N, and `out_valid`=1 after edge N.
- Pop takes effect at the edge. The next head is presented in the same cycle as the updated `level`.
- `alarm` rises at the edge that pushes the `FAULT_LIMIT`-th consecutive fault.
- `evnt_in` is combinational upstream and must be stable at the edge. No internal synchroniser.
- Reset asserted mid-operation empties the FIFO immediately, with pending entries lost. `out_valid` drops asynchronously.

## Configuration
- `TRAIN_EVLOG_TS_EN` defined: the `ts` counter exists and FIFO entries are 4+TS_W bits wide.
- Not defined: the `ts` counter is removed, entries are 4 bits wide, and `out_ts` is tied to 0. The port is still present, so instantiations do not change.

## Structure
- Shared package `train_pkg`:
  - Event-code localparams: EV_GOTOWORK=0000, EV_STOPWORK=0001, EV_GOTOST=0010, EV_WAIT=0011, EV_DRSOPEN=0100, EV_DRSCNTOPEN=0101, EV_DRSCLOSE=0110, EV_DRSCNTCLOSE=0111, EV_SMTHWRONG=1000.
  - Function `is_fault(code)`.
- One sub-module, `evlog_fifo`: parameterised width/depth, show-ahead, push/pop/full/empty/level.
- Change detect, timestamp and fault logic stay in the top module.

## Test plan
- Reset, then `evnt_in`=0001 held → one entry {0001, ts=0}. `out_valid` rises after the first edge, and `level` stays 1 with no further pushes.
- Sequence 0000,0010,0011,0100 on consecutive cycles with `out_ready`=0 → `level`=5 (including the initial entry). Draining yields the codes in order with consecutive timestamps.
- DEPTH=8, `out_ready`=0, 10 distinct changes → `level`=8 and `overflow`=1. The first 8 entries are intact. Then a push and pop in the same cycle while full → `level`=8 with no loss.
- Codes 1000,0101,0111 → `alarm`=1 on the third push. A following 0100 keeps `alarm`=1 and clears `fault_cnt`. 0000 clears `alarm`.
- `ts` preloaded near wrap (TS_W=4): change at ts=15, then at ts=0 → logged timestamps are 15 and 0.
- Assert `reset` with `level`=5 → `out_valid`=0, `level`=0 and `overflow`=0 immediately. The first post-reset code is logged.
